demux_deser16: RTL and testbench

//  Serial-to-parallel demultiplexer: the receive-side counterpart of the 16:1 bit mux.

---
 rtl/demux_deser_pkg.sv | 13 +
 rtl/demux1x16.sv | 18 +
 rtl/demux_deser16.sv | 86 ++++++++
 tb/tb_demux_deser16.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/demux_deser_pkg.sv
// Shared definitions for the serial-to-parallel demux path.
// FSM state encoding and default word geometry.
package demux_deser_pkg;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_HOLD    = 1'b1
    } state_t;

    localparam int unsigned DEF_WIDTH = 16;
    localparam int unsigned DEF_SEL_W = 4;

endpackage

// File: rtl/demux1x16.sv
// 1:WIDTH write-enable decoder: steers a single beat onto slot sel.
// Structural inverse of the mux16x1 select path.
module demux1x16
    import demux_deser_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned SEL_W = DEF_SEL_W
) (
    input  logic             beat,
    input  logic [SEL_W-1:0] sel,
    output logic [WIDTH-1:0] wr_en
);

    always_comb begin
        wr_en = {{(WIDTH-1){1'b0}}, beat} << sel;
    end

endmodule

// File: rtl/demux_deser16.sv
// Serial-to-parallel demultiplexer: collects WIDTH bits one per beat into a
// staging word and presents the completed word over a valid/ready handshake.
module demux_deser16
    import demux_deser_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned SEL_W     = DEF_SEL_W,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_bit,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_word,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SEL_W-1:0] sel
);

    localparam logic [SEL_W-1:0] SEL_START = LSB_FIRST ? SEL_W'(0) : SEL_W'(WIDTH - 1);
    localparam logic [SEL_W-1:0] SEL_LAST  = LSB_FIRST ? SEL_W'(WIDTH - 1) : SEL_W'(0);

    state_t           state;
    logic             beat;
    logic [WIDTH-1:0] wr_en;
    logic [SEL_W-1:0] sel_next;

    assign beat = in_valid & in_ready;

    // Power-of-two WIDTH lets the step wrap naturally back to SEL_START.
    assign sel_next = LSB_FIRST ? (sel + SEL_W'(1)) : (sel - SEL_W'(1));

    demux1x16 #(
        .WIDTH (WIDTH),
        .SEL_W (SEL_W)
    ) u_dec (
        .beat  (beat),
        .sel   (sel),
        .wr_en (wr_en)
    );

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state     <= ST_COLLECT;
            out_word  <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            sel       <= SEL_START;
        end else begin
            case (state)
                ST_COLLECT: begin
                    if (beat) begin
                        for (int unsigned i = 0; i < WIDTH; i++) begin
                            if (wr_en[i]) begin
                                out_word[i] <= in_bit;
                            end
                        end
                        sel <= sel_next;
                        if (sel == SEL_LAST) begin
                            state     <= ST_HOLD;
                            out_valid <= 1'b1;
                            in_ready  <= 1'b0;
                        end
                    end
                end
                ST_HOLD: begin
                    // Zeroing here keeps unwritten slots of the next frame at 0.
                    if (out_ready) begin
                        state     <= ST_COLLECT;
                        out_word  <= '0;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_COLLECT;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_demux_deser16.sv
// Self-checking bench for demux_deser16: one LSB-first and one MSB-first instance.
module tb_demux_deser16;

    logic        clk = 1'b0;
    logic        rst, clear;
    logic        in_bit, in_valid, out_ready, in_ready, out_valid;
    logic [15:0] out_word;
    logic [3:0]  sel;
    logic        b_in_bit, b_in_valid, b_out_ready, b_in_ready, b_out_valid;
    logic [15:0] b_out_word;
    logic [3:0]  b_sel;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    demux_deser16 #(.WIDTH(16), .SEL_W(4), .LSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .clear(clear), .in_bit(in_bit), .in_valid(in_valid),
        .in_ready(in_ready), .out_word(out_word), .out_valid(out_valid),
        .out_ready(out_ready), .sel(sel)
    );

    demux_deser16 #(.WIDTH(16), .SEL_W(4), .LSB_FIRST(1'b0)) dut_msb (
        .clk(clk), .rst(rst), .clear(clear), .in_bit(b_in_bit), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .out_word(b_out_word), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .sel(b_sel)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [15:0] w);
        for (int k = 0; k < 16; k++) begin
            in_valid = 1'b1;
            in_bit   = w[k];
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_bit = 1'b0; b_out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++; if (out_word !== 16'h0) begin n_fail++; $display("FAIL reset_out_word got %h want 0000", out_word); end
        n_checks++; if (sel !== 4'd0) begin n_fail++; $display("FAIL reset_sel got %0d want 0", sel); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_checks++; if (b_sel !== 4'd15) begin n_fail++; $display("FAIL reset_msb_sel got %0d want 15", b_sel); end
    endtask

    task automatic test_lsb_pattern;
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            n_checks++; if (sel !== 4'(k)) begin n_fail++; $display("FAIL pattern_sel got %0d want %0d", sel, k); end
            in_valid = 1'b1;
            in_bit   = (k % 2 == 0);
            tick();
        end
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL pattern_out_valid got %b want 1", out_valid); end
        n_checks++; if (out_word !== 16'h5555) begin n_fail++; $display("FAIL pattern_word got %h want 5555", out_word); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL pattern_in_ready got %b want 0", in_ready); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL pattern_after_hs_valid got %b want 0", out_valid); end
        n_checks++; if (sel !== 4'd0) begin n_fail++; $display("FAIL pattern_after_hs_sel got %0d want 0", sel); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL pattern_after_hs_ready got %b want 1", in_ready); end
        n_checks++; if (out_word !== 16'h0) begin n_fail++; $display("FAIL pattern_after_hs_word got %h want 0000", out_word); end
    endtask

    task automatic test_backpressure;
        logic [15:0] w;
        w = 16'hA5C3;
        out_ready = 1'b0;
        send_frame(w);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_bit   = 1'($urandom_range(0, 1));
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid cycle %0d got %b want 1", c, out_valid); end
            n_checks++; if (out_word !== w) begin n_fail++; $display("FAIL bp_word cycle %0d got %h want %h", c, out_word, w); end
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cycle %0d got %b want 0", c, in_ready); end
            n_checks++; if (sel !== 4'd0) begin n_fail++; $display("FAIL bp_sel cycle %0d got %0d want 0", c, sel); end
            tick();
        end
        in_valid  = 1'b0;
        n_checks++; if (out_word !== w) begin n_fail++; $display("FAIL bp_word_final got %h want %h", out_word, w); end
        out_ready = 1'b1;
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_handshake_valid got %b want 0", out_valid); end
        n_checks++; if (out_word !== 16'h0) begin n_fail++; $display("FAIL bp_handshake_word got %h want 0000", out_word); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_single_handshake got %b want 0", out_valid); end
    endtask

    task automatic test_gaps;
        logic [15:0] w;
        int unsigned g;
        w = 16'h00FF;
        out_ready = 1'b0;
        for (int k = 0; k < 16; k++) begin
            g = $urandom_range(1, 4);
            in_valid = 1'b0;
            repeat (g) begin
                tick();
                n_checks++; if (sel !== 4'(k)) begin n_fail++; $display("FAIL gap_sel got %0d want %0d", sel, k); end
            end
            in_valid = 1'b1;
            in_bit   = w[k];
            tick();
        end
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL gap_valid got %b want 1", out_valid); end
        n_checks++; if (out_word !== w) begin n_fail++; $display("FAIL gap_word got %h want %h", out_word, w); end
        out_ready = 1'b1;
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL gap_handshake got %b want 0", out_valid); end
    endtask

    task automatic test_clear;
        logic [15:0] r;
        out_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            in_valid = 1'b1; in_bit = 1'b1; tick();
        end
        n_checks++; if (sel !== 4'd7) begin n_fail++; $display("FAIL clear_pre_sel got %0d want 7", sel); end
        clear = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
        tick();
        clear = 1'b0; in_valid = 1'b0;
        n_checks++; if (sel !== 4'd0) begin n_fail++; $display("FAIL clear_sel got %0d want 0", sel); end
        n_checks++; if (out_word !== 16'h0) begin n_fail++; $display("FAIL clear_word got %h want 0000", out_word); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL clear_in_ready got %b want 1", in_ready); end
        out_ready = 1'b0;
        send_frame(16'hFFFF);
        n_checks++; if (out_word !== 16'hFFFF) begin n_fail++; $display("FAIL clear_full_word got %h want ffff", out_word); end
        // clear while holding discards the word even with out_ready high
        out_ready = 1'b1; clear = 1'b1;
        tick();
        clear = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL clear_hold_valid got %b want 0", out_valid); end
        n_checks++; if (out_word !== 16'h0) begin n_fail++; $display("FAIL clear_hold_word got %h want 0000", out_word); end
        for (int k = 0; k < 7; k++) begin
            in_valid = 1'b1; in_bit = 1'b1; tick();
        end
        clear = 1'b1; in_valid = 1'b0;
        tick();
        clear = 1'b0; out_ready = 1'b0;
        send_frame(16'h1234);
        n_checks++; if (out_word !== 16'h1234) begin n_fail++; $display("FAIL clear_stale_word got %h want 1234", out_word); end
        r = 16'($urandom);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        send_frame(r);
        n_checks++; if (out_word !== r) begin n_fail++; $display("FAIL rst_pre_word got %h want %h", out_word, r); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_hold_valid got %b want 0", out_valid); end
        n_checks++; if (out_word !== 16'h0) begin n_fail++; $display("FAIL rst_hold_word got %h want 0000", out_word); end
        n_checks++; if (sel !== 4'd0) begin n_fail++; $display("FAIL rst_hold_sel got %0d want 0", sel); end
    endtask

    task automatic test_round_trip;
        logic [15:0] w;
        w = 16'h5555;
        out_ready = 1'b1; b_out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            n_checks++; if (sel !== 4'(k)) begin n_fail++; $display("FAIL rt_sel got %0d want %0d", sel, k); end
            n_checks++; if (b_sel !== 4'(15 - k)) begin n_fail++; $display("FAIL rt_msb_sel got %0d want %0d", b_sel, 15 - k); end
            in_valid = 1'b1;   in_bit = w[k];
            b_in_valid = 1'b1; b_in_bit = w[15 - k];
            tick();
        end
        in_valid = 1'b0; b_in_valid = 1'b0;
        n_checks++; if (out_word !== w) begin n_fail++; $display("FAIL rt_word got %h want %h", out_word, w); end
        n_checks++; if (b_out_word !== w) begin n_fail++; $display("FAIL rt_msb_word got %h want %h", b_out_word, w); end
        n_checks++; if (b_out_valid !== 1'b1) begin n_fail++; $display("FAIL rt_msb_valid got %b want 1", b_out_valid); end
        tick();
        n_checks++; if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL rt_msb_handshake got %b want 0", b_out_valid); end
    endtask

    task automatic test_random;
        logic [15:0] bits, exp_a, exp_b;
        int unsigned stall;
        for (int f = 0; f < 20; f++) begin
            out_ready = 1'b0; b_out_ready = 1'b0;
            bits = 16'($urandom);
            // beat k lands at slot k (LSB-first) or slot 15-k (MSB-first)
            exp_a = '0; exp_b = '0;
            for (int k = 0; k < 16; k++) begin
                exp_a[k]      = bits[k];
                exp_b[15 - k] = bits[k];
            end
            for (int k = 0; k < 16; k++) begin
                in_valid = 1'b0; b_in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) tick();
                n_checks++; if (sel !== 4'(k)) begin n_fail++; $display("FAIL rand_sel frame %0d got %0d want %0d", f, sel, k); end
                in_valid = 1'b1;   in_bit = bits[k];
                b_in_valid = 1'b1; b_in_bit = bits[k];
                tick();
            end
            in_valid = 1'b0; b_in_valid = 1'b0;
            stall = $urandom_range(0, 3);
            for (int s = 0; s <= int'(stall); s++) begin
                n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rand_valid frame %0d got %b want 1", f, out_valid); end
                n_checks++; if (out_word !== exp_a) begin n_fail++; $display("FAIL rand_word frame %0d got %h want %h", f, out_word, exp_a); end
                n_checks++; if (b_out_word !== exp_b) begin n_fail++; $display("FAIL rand_msb_word frame %0d got %h want %h", f, b_out_word, exp_b); end
                if (s == int'(stall)) begin
                    out_ready = 1'b1; b_out_ready = 1'b1;
                end
                tick();
            end
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rand_handshake frame %0d got %b want 0", f, out_valid); end
            n_checks++; if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL rand_msb_handshake frame %0d got %b want 0", f, b_out_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_lsb_pattern();
        test_backpressure();
        test_gaps();
        test_clear();
        test_round_trip();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
